// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv32_pkg                                                        |
// | Brief    : Shared encodings for the rv32i MEM/WB stage                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rv32_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        MWB_IDLE      = 1'b0,
        MWB_WAIT_LOAD = 1'b1
    } mwb_state_t;

endpackage
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_align_unit                                                 |
// | Brief    : Lane select and sign/zero extension of word-aligned load data.  |
// |            Misalign flag present when MEM_WB_MISALIGN_CHECK_EN is defined. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module load_align_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
`ifdef MEM_WB_MISALIGN_CHECK_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] aligned_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        // Half lane ignores addr[0]; misaligned halves are flagged, not fixed up
        w_half = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   aligned_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   aligned_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  aligned_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  aligned_data = {{(XLEN-16){1'b0}}, w_half};
            default: aligned_data = dmem_rdata;
        endcase
    end

`ifdef MEM_WB_MISALIGN_CHECK_EN
    always_comb begin
        case (funct3)
            F3_LB, F3_LBU: misalign = 1'b0;
            F3_LH, F3_LHU: misalign = addr[0];
            default:       misalign = (addr != 2'b00);
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_wb_stage                                                    |
// | Brief    : rv32i MEM/WB pipeline register with load-wait FSM and           |
// |            write-back select. Optional MEM_WB_MISALIGN_CHECK_EN.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_wb_stage
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EX_MEM_valid,
    input  logic            EX_MEM_RegWrite,
    input  logic            EX_MEM_MemRead,
    input  logic [1:0]      EX_MEM_WbSel,
    input  logic [2:0]      EX_MEM_Funct3,
    input  logic [4:0]      EX_MEM_RegisterRd,
    input  logic [XLEN-1:0] EX_MEM_ALUResult,
    input  logic [XLEN-1:0] EX_MEM_PCPlus4,
    input  logic            flush,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            MEM_WB_valid,
    output logic            MEM_WB_RegWrite,
    output logic [4:0]      MEM_WB_RegisterRd,
    output logic [XLEN-1:0] MEM_WB_WriteData,
    output logic            misalign_err
);

    mwb_state_t      r_state;
    mwb_state_t      w_next_state;
    logic            r_drop;
    logic            w_drop_next;
    logic            w_capture;
    logic            w_bad_load;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wb_data;

`ifdef MEM_WB_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_misalign_err;

    load_align_unit #(.XLEN(XLEN)) u_align (
        .dmem_rdata   (dmem_rdata),
        .addr         (EX_MEM_ALUResult[1:0]),
        .funct3       (EX_MEM_Funct3),
        .misalign     (w_misalign),
        .aligned_data (w_load_data)
    );

    assign w_bad_load   = EX_MEM_MemRead && w_misalign;
    assign misalign_err = r_misalign_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else if (w_capture && w_bad_load) begin
            r_misalign_err <= 1'b1;
        end
    end
`else
    load_align_unit #(.XLEN(XLEN)) u_align (
        .dmem_rdata   (dmem_rdata),
        .addr         (EX_MEM_ALUResult[1:0]),
        .funct3       (EX_MEM_Funct3),
        .aligned_data (w_load_data)
    );

    assign w_bad_load   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        case (EX_MEM_WbSel)
            WB_MEM:  w_wb_data = w_load_data;
            WB_PC4:  w_wb_data = EX_MEM_PCPlus4;
            default: w_wb_data = EX_MEM_ALUResult;
        endcase
    end

    // w_capture: the current instruction is written into MEM/WB this edge
    always_comb begin
        w_next_state = r_state;
        w_drop_next  = r_drop;
        w_capture    = 1'b0;
        mem_stall    = 1'b0;
        case (r_state)
            MWB_IDLE: begin
                if (EX_MEM_valid && !flush) begin
                    if (EX_MEM_MemRead && !dmem_rsp_valid) begin
                        mem_stall    = 1'b1;
                        w_next_state = MWB_WAIT_LOAD;
                    end else begin
                        w_capture = 1'b1;
                    end
                end
            end
            MWB_WAIT_LOAD: begin
                if (dmem_rsp_valid) begin
                    w_next_state = MWB_IDLE;
                    w_capture    = !(r_drop || flush);
                    w_drop_next  = 1'b0;
                end else begin
                    mem_stall = 1'b1;
                    if (flush) begin
                        w_drop_next = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = MWB_IDLE;
                w_drop_next  = 1'b0;
            end
        endcase
        // Upstream is also in reset; never hold it frozen
        if (!rst_n) begin
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MWB_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_drop  <= w_drop_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_WB_valid      <= 1'b0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_RegisterRd <= 5'd0;
            MEM_WB_WriteData  <= '0;
        end else if (w_capture) begin
            MEM_WB_valid      <= 1'b1;
            MEM_WB_RegWrite   <= EX_MEM_RegWrite && (EX_MEM_RegisterRd != 5'd0) && !w_bad_load;
            MEM_WB_RegisterRd <= EX_MEM_RegisterRd;
            MEM_WB_WriteData  <= w_wb_data;
        end else begin
            MEM_WB_valid      <= 1'b0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_RegisterRd <= 5'd0;
            MEM_WB_WriteData  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_wb_stage                                                 |
// | Brief    : Directed scoreboard bench for mem_wb_stage                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem_wb_stage;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_rw, ex_mr, fl, rsp;
    logic [1:0]  ex_wbsel;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu, ex_pc4, rdata;
    logic        stall, wb_valid, wb_rw, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

`ifdef MEM_WB_MISALIGN_CHECK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    mem_wb_stage #(.XLEN(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .EX_MEM_valid      (ex_valid),
        .EX_MEM_RegWrite   (ex_rw),
        .EX_MEM_MemRead    (ex_mr),
        .EX_MEM_WbSel      (ex_wbsel),
        .EX_MEM_Funct3     (ex_f3),
        .EX_MEM_RegisterRd (ex_rd),
        .EX_MEM_ALUResult  (ex_alu),
        .EX_MEM_PCPlus4    (ex_pc4),
        .flush             (fl),
        .dmem_rsp_valid    (rsp),
        .dmem_rdata        (rdata),
        .mem_stall         (stall),
        .MEM_WB_valid      (wb_valid),
        .MEM_WB_RegWrite   (wb_rw),
        .MEM_WB_RegisterRd (wb_rd),
        .MEM_WB_WriteData  (wb_data),
        .misalign_err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic mr, input logic [1:0] ws,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic r, input logic [31:0] rdat);
        ex_valid = v;  ex_rw = rw; ex_mr = mr; ex_wbsel = ws; ex_f3 = f3;
        ex_rd = rd;    ex_alu = alu; ex_pc4 = pc4; rsp = r; rdata = rdat;
    endtask

    task automatic expect_wb(input logic rw, input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.rw = rw; e.rd = rd; e.data = d; e.err = exp_err;
        q.push_back(e);
    endtask

    // Monitor: every valid MEM/WB output is matched against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got rd %0d data %h expected nothing", wb_rd, wb_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wb_regwrite", {31'd0, wb_rw}, {31'd0, e.rw});
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    check("wb_data", wb_data, e.data);
                    check("wb_misalign_err", {31'd0, err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        fl    = 1'b0;
        set_in(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        #12;
        check("reset_valid", {31'd0, wb_valid}, 32'd0);
        check("reset_rw", {31'd0, wb_rw}, 32'd0);
        check("reset_data", wb_data, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        cyc();
        rst_n = 1'b1;

        // ALU op
        set_in(1, 1, 0, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0);
        expect_wb(1, 5'd5, 32'h0000_1234);
        #1 check("alu_stall", {31'd0, stall}, 32'd0);
        cyc();

        // Zero-wait loads of each width/lane
        set_in(1, 1, 1, 2'b01, 3'b000, 5'd6, 32'h0000_1003, 32'h0, 1, 32'h80FF_FF7F);
        expect_wb(1, 5'd6, 32'hFFFF_FF80);
        #1 check("lb_stall", {31'd0, stall}, 32'd0);
        cyc();
        set_in(1, 1, 1, 2'b01, 3'b101, 5'd7, 32'h0000_1002, 32'h0, 1, 32'h80FF_FF7F);
        expect_wb(1, 5'd7, 32'h0000_80FF);
        cyc();
        set_in(1, 1, 1, 2'b01, 3'b001, 5'd11, 32'h0000_1000, 32'h0, 1, 32'h80FF_FF7F);
        expect_wb(1, 5'd11, 32'hFFFF_FF7F);
        cyc();
        set_in(1, 1, 1, 2'b01, 3'b100, 5'd12, 32'h0000_1001, 32'h0, 1, 32'h80FF_FF7F);
        expect_wb(1, 5'd12, 32'h0000_00FF);
        cyc();

        // lw with 3 wait cycles
        set_in(1, 1, 1, 2'b01, 3'b010, 5'd8, 32'h0000_2000, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 check("lw_wait_stall", {31'd0, stall}, 32'd1);
            cyc();
            check("lw_wait_bubble_valid", {31'd0, wb_valid}, 32'd0);
            check("lw_wait_bubble_rw", {31'd0, wb_rw}, 32'd0);
        end
        rsp = 1'b1; rdata = 32'hDEAD_BEEF;
        expect_wb(1, 5'd8, 32'hDEAD_BEEF);
        #1 check("lw_rsp_stall", {31'd0, stall}, 32'd0);
        cyc();

        // Flush while waiting: response consumed, bubble out
        set_in(1, 1, 1, 2'b01, 3'b010, 5'd9, 32'h0000_2004, 32'h0, 0, 32'h0);
        cyc();
        fl = 1'b1;
        #1 check("flush_wait_stall", {31'd0, stall}, 32'd1);
        cyc();
        fl = 1'b0;
        #1 check("flush_after_stall", {31'd0, stall}, 32'd1);
        cyc();
        rsp = 1'b1; rdata = 32'h1111_2222;
        #1 check("flush_rsp_stall", {31'd0, stall}, 32'd0);
        cyc();
        check("flush_bubble_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_bubble_rw", {31'd0, wb_rw}, 32'd0);
        // Back in IDLE: a non-load with no response does not stall
        set_in(1, 1, 0, 2'b00, 3'b000, 5'd3, 32'h0000_0033, 32'h0, 0, 32'h0);
        expect_wb(1, 5'd3, 32'h0000_0033);
        #1 check("post_flush_idle_stall", {31'd0, stall}, 32'd0);
        cyc();

        // jal to x0
        set_in(1, 1, 0, 2'b10, 3'b000, 5'd0, 32'h0000_0044, 32'h0000_0100, 0, 32'h0);
        expect_wb(0, 5'd0, 32'h0000_0100);
        cyc();

        // Invalid slot with a stray response, then flushed load in IDLE
        set_in(0, 1, 1, 2'b01, 3'b010, 5'd4, 32'h0000_0000, 32'h0, 1, 32'h5555_5555);
        cyc();
        set_in(1, 1, 1, 2'b01, 3'b010, 5'd4, 32'h0000_0000, 32'h0, 0, 32'h0);
        fl = 1'b1;
        #1 check("flush_idle_stall", {31'd0, stall}, 32'd0);
        cyc();
        fl = 1'b0;
        check("flush_idle_bubble", {31'd0, wb_valid}, 32'd0);

        // Misaligned lw at ...02
        set_in(1, 1, 1, 2'b01, 3'b010, 5'd10, 32'h0000_3002, 32'h0, 1, 32'h1234_5678);
        exp_err = MIS_EN;
        expect_wb(!MIS_EN, 5'd10, 32'h1234_5678);
        cyc();
        set_in(1, 1, 0, 2'b00, 3'b000, 5'd13, 32'h0000_0077, 32'h0, 0, 32'h0);
        expect_wb(1, 5'd13, 32'h0000_0077);
        cyc();

        // Reset in the middle of a load wait
        set_in(1, 1, 1, 2'b01, 3'b010, 5'd14, 32'h0000_4000, 32'h0, 0, 32'h0);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_mid_rw", {31'd0, wb_rw}, 32'd0);
        check("rst_mid_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_mid_data", wb_data, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        exp_err = 1'b0;
        set_in(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        cyc();
        rst_n = 1'b1;
        set_in(1, 1, 0, 2'b00, 3'b000, 5'd15, 32'h0000_0099, 32'h0, 0, 32'h0);
        expect_wb(1, 5'd15, 32'h0000_0099);
        #1 check("post_rst_stall", {31'd0, stall}, 32'd0);
        cyc();
        set_in(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        cyc();
        cyc();
        check("scoreboard_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
